// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32 core constants
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_1000;
  localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch stage buses: imem request/response, redirect, decode handoff
interface ifetch_unit_if;

  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [core_pkg::XLEN-1:0] imem_req_addr;
  logic                     imem_resp_valid;
  logic [core_pkg::XLEN-1:0] imem_resp_data;
  logic                     redirect_valid;
  logic [core_pkg::XLEN-1:0] redirect_pc;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [core_pkg::XLEN-1:0] dec_inst;
  logic [core_pkg::XLEN-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - instruction buffer; flush dominates push and pop
module ifetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [XLEN-1:0]          din,
  output logic [XLEN-1:0]          dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC, request credit and stale-response drop logic of the fetch stage
module ifetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic            rst_q;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] head_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] fifo_dout;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic            req_fire;
  logic            resp_stale;
  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned = bus.redirect_pc & INST_ALIGN_MASK;

  // Credit uses registered counts only; a slot freed this cycle is reused next cycle.
  assign bus.imem_req_valid = !rst_q && !bus.redirect_valid &&
                              (({1'b0, inflight} + {1'b0, fifo_count}) < CREDITS);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign resp_stale = (drop_cnt != '0);
  assign fifo_push  = bus.imem_resp_valid && !resp_stale && !bus.redirect_valid;
  assign fifo_pop   = !fifo_empty && bus.dec_ready;

  assign bus.dec_valid = !fifo_empty;
  assign bus.dec_inst  = fifo_empty ? NOP_INST : fifo_dout;
  assign bus.dec_pc    = head_pc;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (bus.redirect_valid),
    .din   (bus.imem_resp_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_resp_valid);
      if (bus.redirect_valid) begin
        fetch_pc <= redirect_aligned;
        head_pc  <= redirect_aligned;
        // Everything still outstanding after this cycle belongs to the old path.
        drop_cnt <= inflight - CW'(bus.imem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (fifo_pop) head_pc <= head_pc + 32'd4;
        if (bus.imem_resp_valid && resp_stale) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
  a_drop_bound:  assert property (@(posedge clk) disable iff (rst) drop_cnt <= inflight);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed bench for ifetch_unit with a fixed-latency memory model
module tb_ifetch_unit;
  import core_pkg::*;

  logic clk;
  logic rst;
  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(32'h0000_1000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          lat;
  int          n_consumed;
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes and consumption before the edge, then update memory after it.
  task automatic tick();
    logic        hs;
    logic [31:0] hs_addr;
    logic        was_rst;
    #1;
    hs      = bus.imem_req_valid && bus.imem_req_ready;
    hs_addr = bus.imem_req_addr;
    was_rst = rst;
    if (!rst && !bus.redirect_valid && bus.dec_valid && bus.dec_ready) begin
      check("consume_pc", bus.dec_pc, exp_pc);
      check("consume_inst", bus.dec_inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (hs) begin
      pend_addr.push_back(hs_addr);
      pend_due.push_back(cyc + lat - 1);
    end
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      void'(pend_due.pop_front());
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(pend_addr.pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int latency, input logic rdy);
    lat                = latency;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = rdy;
    exp_pc             = 32'h0000_1000;
    n_consumed         = 0;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    exp_pc             = pc & INST_ALIGN_MASK;
  endtask

  initial begin
    n_checks            = 0;
    n_errors            = 0;
    cyc                 = 0;
    rst                 = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;

    // 1: reset state, first-fetch latency, in-order stream
    do_reset(1, 1'b1);
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 0);
    check("rst_dec_valid", 32'(bus.dec_valid), 0);
    check("rst_dec_inst", bus.dec_inst, 32'h0000_0013);
    check("rst_dec_pc", bus.dec_pc, 32'h0000_1000);
    tick();
    check("t1_req_valid", 32'(bus.imem_req_valid), 1);
    check("t1_req_addr", bus.imem_req_addr, 32'h0000_1000);
    check("t1_dec_valid_c0", 32'(bus.dec_valid), 0);
    tick();
    check("t1_dec_valid_c1", 32'(bus.dec_valid), 0);
    check("t1_req_addr_c1", bus.imem_req_addr, 32'h0000_1004);
    tick();
    check("t1_dec_valid_c2", 32'(bus.dec_valid), 1);
    check("t1_dec_pc_c2", bus.dec_pc, 32'h0000_1000);
    ticks(10);
    check("t1_progress", 32'(n_consumed >= 4), 1);

    // 2: decode stall holds the head and starves the request channel
    do_reset(1, 1'b0);
    ticks(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold_valid", 32'(bus.dec_valid), 1);
      check("t2_hold_pc", bus.dec_pc, 32'h0000_1000);
      check("t2_hold_inst", bus.dec_inst, mem_word(32'h0000_1000));
      check("t2_req_blocked", 32'(bus.imem_req_valid), 0);
    end
    bus.dec_ready = 1'b1;
    ticks(8);
    check("t2_progress", 32'(n_consumed >= 4), 1);

    // 3: redirect with two requests in flight, 3-cycle memory
    do_reset(3, 1'b1);
    ticks(3);
    redirect_to(32'h0000_2002);
    #1;
    check("t3_req_in_redirect", 32'(bus.imem_req_valid), 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t3_dec_valid", 32'(bus.dec_valid), 0);
    check("t3_dec_pc", bus.dec_pc, 32'h0000_2000);
    check("t3_req_no_credit", 32'(bus.imem_req_valid), 0);
    tick();
    check("t3_req_resume", 32'(bus.imem_req_valid), 1);
    check("t3_req_addr", bus.imem_req_addr, 32'h0000_2000);
    ticks(14);
    check("t3_progress", 32'(n_consumed >= 2), 1);

    // 4a: redirect alone blocks a request that credit would allow
    do_reset(1, 1'b1);
    tick();
    redirect_to(32'h0000_6000);
    #1;
    check("t4a_req_blocked", 32'(bus.imem_req_valid), 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t4a_req_addr", bus.imem_req_addr, 32'h0000_6000);
    check("t4a_req_valid", 32'(bus.imem_req_valid), 1);

    // 4b: redirect coincides with a response and a ready decode
    do_reset(1, 1'b1);
    ticks(3);
    check("t4b_pre_resp", 32'(bus.imem_resp_valid), 1);
    check("t4b_pre_dec_valid", 32'(bus.dec_valid), 1);
    redirect_to(32'h0000_5000);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t4b_dec_valid", 32'(bus.dec_valid), 0);
    check("t4b_req_valid", 32'(bus.imem_req_valid), 1);
    check("t4b_req_addr", bus.imem_req_addr, 32'h0000_5000);
    ticks(2);
    check("t4b_first_valid", 32'(bus.dec_valid), 1);
    check("t4b_first_pc", bus.dec_pc, 32'h0000_5000);
    ticks(8);
    check("t4b_progress", 32'(n_consumed >= 3), 1);

    // 5: back-to-back redirects
    do_reset(3, 1'b1);
    ticks(3);
    redirect_to(32'h0000_3000);
    tick();
    redirect_to(32'h0000_4000);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t5_req_valid", 32'(bus.imem_req_valid), 1);
    check("t5_req_addr", bus.imem_req_addr, 32'h0000_4000);
    check("t5_dec_pc", bus.dec_pc, 32'h0000_4000);
    ticks(14);
    check("t5_progress", 32'(n_consumed >= 2), 1);

    // 6: reset mid-stream with a full buffer
    do_reset(1, 1'b0);
    ticks(6);
    check("t6_full_valid", 32'(bus.dec_valid), 1);
    check("t6_full_req", 32'(bus.imem_req_valid), 0);
    rst = 1'b1;
    tick();
    check("t6_rst_dec_valid", 32'(bus.dec_valid), 0);
    check("t6_rst_dec_inst", bus.dec_inst, 32'h0000_0013);
    check("t6_rst_dec_pc", bus.dec_pc, 32'h0000_1000);
    check("t6_rst_req", 32'(bus.imem_req_valid), 0);
    rst = 1'b0;
    tick();
    check("t6_restart_req", 32'(bus.imem_req_valid), 1);
    check("t6_restart_addr", bus.imem_req_addr, 32'h0000_1000);
    bus.dec_ready = 1'b1;
    exp_pc        = 32'h0000_1000;
    n_consumed    = 0;
    ticks(10);
    check("t6_progress", 32'(n_consumed >= 3), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
